ccsds123_frame_ctrl: RTL and testbench
======================================

CCSDS123_FRAME_CTRL -- requirements
Module: ccsds123_frame_ctrl

Interface
REQ-001 SHALL have parameter PIPELINES, default 3: samples per beat.
REQ-002 SHALL have parameter D, default 16: bits per sample.
REQ-003 SHALL have parameters NX, NY, NZ, defaults 500, 500, 100: image dimensions.
REQ-004 SHALL derive local BEATS = ceil(NX*NY*NZ/PIPELINES) and REM = NX*NY*NZ mod PIPELINES.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1: run request.
REQ-008 SHALL have port s_axis_tdata, input, PIPELINES*D: sample beat from DMA.
REQ-009 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tlast (input, 1).
REQ-010 SHALL have port m_axis_tdata, output, PIPELINES*D: beat to compressor.
REQ-011 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1).
REQ-012 SHALL have port m_axis_tkeep, output, PIPELINES: valid-lane mask; lane i = bits [i*D +: D].
REQ-013 SHALL have port m_axis_tuser, output, 1: first beat of an image.
REQ-014 SHALL have port frame_count, output, 16: images completed, wrapping.
REQ-015 SHALL have ports busy (output, 1), err_tlast (output, 1), err_clear (input, 1).

Function
REQ-016 SHALL implement FSM IDLE/RUN/DRAIN: IDLE->RUN on enable=1; RUN->DRAIN on enable=0; DRAIN->IDLE after the image's last beat is accepted downstream; DRAIN->RUN on enable=1 before that.
REQ-017 SHALL also go RUN->IDLE when the last beat of an image is accepted downstream and enable=0 in that cycle.
REQ-018 SHALL hold s_axis_tready=0 in IDLE; busy=1 in RUN and DRAIN.
REQ-019 SHALL forward beats through a 2-entry skid buffer: latency 1 cycle, full throughput while m_axis_tready=1, no combinational path from m_axis_tready to s_axis_tready.
REQ-020 SHALL keep a beat counter of width $clog2(BEATS+1), incremented per accepted input beat, wrapping to 0 after beat BEATS-1.
REQ-021 SHALL tag beat 0 with tuser=1 and beat BEATS-1 with tlast=1, carried with the data through the buffer.
REQ-022 SHALL drive tkeep all-ones, except on the last beat when REM!=0: lowest REM bits set.
REQ-023 SHALL stop accepting input in DRAIN once beat BEATS-1 has been accepted.
REQ-024 SHALL increment frame_count when a tlast beat handshakes on the master side; 16'hFFFF wraps to 0.
REQ-025 SHALL hold m_axis_tdata/tlast/tkeep/tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 SHALL start back-to-back images with no idle cycle while enable=1.

Reset
REQ-027 SHALL, while aresetn=0: FSM=IDLE, beat counter=0, buffer empty, m_axis_tvalid=0, s_axis_tready=0, tlast/tuser=0, tkeep=0, frame_count=0, busy=0, err_tlast=0.
REQ-028 SHALL, on reset mid-image, discard buffered beats; the first beat accepted after reset is beat 0.

Configuration
REQ-029 SHALL, with CCSDS123_TLAST_CHECK_EN defined, set sticky err_tlast when an accepted beat's s_axis_tlast differs from the internal last flag; err_clear=1 clears it, and a simultaneous set wins over the clear.
REQ-030 SHALL, without CCSDS123_TLAST_CHECK_EN, ignore s_axis_tlast and tie err_tlast to 0.
REQ-031 SHALL never let err_tlast alter data flow or counting.

Structure
REQ-032 SHALL place the FSM state encoding and a ceil-division helper function in package ccsds123_pkg.
REQ-033 SHALL implement the skid buffer as sub-module ccsds123_skid_buf, parameterised by width.

Verification
REQ-034 SHALL cover: PIPELINES=3, NX=4, NY=2, NZ=5, enable=1, continuous input -> 14 beats; beat 0 has tuser=1; beat 13 has tlast=1, tkeep=3'b001; frame_count=1.
REQ-035 SHALL cover: same configuration, 2 images back-to-back, m_axis_tready=1 -> 28 output beats in 28 consecutive cycles; frame_count=2.
REQ-036 SHALL cover: m_axis_tready low for 20 cycles mid-image -> no beat lost or duplicated; outputs held stable; s_axis_tready low within 2 cycles.
REQ-037 SHALL cover: enable dropped after beat 5 -> beats 6..13 still delivered, then IDLE with busy=0 and s_axis_tready=0.
REQ-038 SHALL cover: aresetn pulsed at beat 7 -> all outputs at reset values; the next image starts with tuser=1 and a full 14 beats.
REQ-039 SHALL cover: with CCSDS123_TLAST_CHECK_EN, s_axis_tlast=1 on beat 4 -> err_tlast=1 and the output stream unchanged; err_clear=1 -> err_tlast=0.

Source files
------------

// File: rtl/ccsds123_pkg.sv
// Shared types and helpers for the CCSDS-123 frame controller slice.
package ccsds123_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccsds123_skid_buf.sv
// Two-entry skid buffer: registered output, upstream ready depends only on local state.
module ccsds123_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_hs;
  logic             out_free;

  // Ready comes from the skid flag alone, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid;
  assign in_hs    = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_hs;
        if (in_hs) out_data <= in_data;
      end
    end else if (in_hs) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: skid_data needs no reset; it is only observed while skid_valid is set.
  always_ff @(posedge clk) begin
    if (in_hs && !out_free) skid_data <= in_data;
  end

endmodule

// File: rtl/ccsds123_frame_ctrl.sv
// Frames DMA sample beats into images for the CCSDS-123 compressor (tuser/tlast/tkeep tagging).
// Optional build macro CCSDS123_TLAST_CHECK_EN enables the sticky upstream-tlast mismatch flag.
module ccsds123_frame_ctrl
  import ccsds123_pkg::*;
#(
  parameter int PIPELINES = 3,
  parameter int D         = 16,
  parameter int NX        = 500,
  parameter int NY        = 500,
  parameter int NZ        = 100
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [PIPELINES*D-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [PIPELINES*D-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [PIPELINES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tuser,
  output logic [15:0]            frame_count,
  output logic                   busy,
  output logic                   err_tlast,
  input  logic                   err_clear
);

  localparam int TOTAL = NX * NY * NZ;
  localparam int BEATS = ceil_div(TOTAL, PIPELINES);
  localparam int REM   = TOTAL % PIPELINES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int BW    = PIPELINES * D + PIPELINES + 2;

  localparam logic [CW-1:0]        LAST_IDX  = CW'(BEATS - 1);
  localparam logic [PIPELINES-1:0] ALL_KEEP  = '1;
  localparam logic [PIPELINES-1:0] LAST_KEEP = (REM == 0) ? ALL_KEEP : (ALL_KEEP >> (PIPELINES - REM));

  state_e               state, state_nxt;
  logic [CW-1:0]        beat_cnt;
  logic                 accept_en;
  logic                 buf_in_ready;
  logic                 in_hs;
  logic                 first_flag;
  logic                 last_flag;
  logic [PIPELINES-1:0] keep_in;
  logic [BW-1:0]        buf_in;
  logic [BW-1:0]        buf_out;
  logic                 m_last_hs;
  logic                 tail_pending;
  logic                 drain_done;

  assign first_flag = (beat_cnt == '0);
  assign last_flag  = (beat_cnt == LAST_IDX);
  assign keep_in    = last_flag ? LAST_KEEP : ALL_KEEP;
  assign buf_in     = {first_flag, last_flag, keep_in, s_axis_tdata};

  // A new image only starts while enabled; once stopping, only the open image is completed.
  always_comb begin
    accept_en = 1'b0;
    unique case (state)
      ST_RUN:   accept_en = enable || (beat_cnt != '0);
      ST_DRAIN: accept_en = (beat_cnt != '0);
      default:  accept_en = 1'b0;
    endcase
  end

  assign s_axis_tready = accept_en && buf_in_ready;
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  ccsds123_skid_buf #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_data   (buf_in),
    .in_valid  (s_axis_tvalid && accept_en),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = buf_out;
  assign m_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // The image is finished when no beat of a new one was taken and its tail has left downstream.
  assign drain_done = (beat_cnt == '0) && (!tail_pending || m_last_hs);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      tail_pending <= 1'b0;
      frame_count  <= '0;
    end else begin
      state <= state_nxt;
      if (in_hs) beat_cnt <= last_flag ? '0 : beat_cnt + 1'b1;
      if (in_hs && last_flag) tail_pending <= 1'b1;
      else if (m_last_hs)     tail_pending <= 1'b0;
      if (m_last_hs) frame_count <= frame_count + 16'd1;
    end
  end

  // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = (m_last_hs && beat_cnt == '0) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable)          state_nxt = ST_RUN;
        else if (drain_done) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

`ifdef CCSDS123_TLAST_CHECK_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                                    err_tlast <= 1'b0;
    else if (in_hs && (s_axis_tlast != last_flag))   err_tlast <= 1'b1;
    else if (err_clear)                              err_tlast <= 1'b0;
  end
`else
  logic unused_tlast_inputs;
  assign unused_tlast_inputs = s_axis_tlast ^ err_clear;
  assign err_tlast           = 1'b0;
`endif

endmodule

// File: tb/tb_ccsds123_frame_ctrl.sv
// Scoreboard bench for ccsds123_frame_ctrl with a 4x2x5 image over 3 lanes (14 beats, REM=1).
module tb_ccsds123_frame_ctrl;

  localparam int P     = 3;
  localparam int DW    = 16;
  localparam int TDW   = P * DW;
  localparam int BEATS = 14;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic           user;
    logic           last;
    logic [P-1:0]   keep;
  } beat_t;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           enable = 1'b0;
  logic [TDW-1:0] s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [TDW-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [P-1:0]   m_axis_tkeep;
  logic           m_axis_tuser;
  logic [15:0]    frame_count;
  logic           busy;
  logic           err_tlast;
  logic           err_clear = 1'b0;

  ccsds123_frame_ctrl #(.PIPELINES(P), .D(DW), .NX(4), .NY(2), .NZ(5)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .frame_count   (frame_count),
    .busy          (busy),
    .err_tlast     (err_tlast),
    .err_clear     (err_clear)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    pop_cyc_q[$];
  int    cyc = 0;
  int    in_idx = 0;
  int    seq = 0;
  int    in_count = 0;
  int    inject_idx = -1;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t mon_cur;
  beat_t mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TDW-1:0] beat_data(input int s);
    logic [TDW-1:0] d;
    for (int i = 0; i < P; i++) d[i*DW +: DW] = 16'(s * 7 + i * 1001 + 'h1234);
    return d;
  endfunction

  function automatic beat_t expect_beat(input int idx, input logic [TDW-1:0] d);
    beat_t b;
    b.data = d;
    b.user = (idx == 0);
    b.last = (idx == BEATS - 1);
    b.keep = (idx == BEATS - 1) ? 3'b001 : 3'b111;
    return b;
  endfunction

  task automatic present();
    s_axis_tdata = beat_data(seq);
    s_axis_tlast = (in_idx == BEATS - 1) || (in_idx == inject_idx);
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so a ready seen at negedge is a handshake.
  task automatic send_beats(input int n, input int budget);
    int sent = 0;
    int spent = 0;
    present();
    s_axis_tvalid = 1'b1;
    while (sent < n && spent < budget) begin
      @(negedge clk);
      if (s_axis_tready) begin
        exp_q.push_back(expect_beat(in_idx, s_axis_tdata));
        sent++;
        seq++;
        in_count++;
        in_idx = (in_idx + 1) % BEATS;
      end
      @(posedge clk); #1;
      present();
      spent++;
    end
    s_axis_tvalid = 1'b0;
    check("send_budget", sent, n);
  endtask

  task automatic wait_drain(input string name);
    int spent = 0;
    while (exp_q.size() != 0 && spent < 200) begin
      @(negedge clk);
      spent++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    mon_cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tkeep};
    if (prev_stall && aresetn) check("hold_stable", {m_axis_tvalid, mon_cur}, {1'b1, prev_beat});
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", mon_cur);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", mon_cur, mon_exp);
      end
      pop_cyc_q.push_back(cyc);
    end
    prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
    prev_beat  = mon_cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int w;
  int cnt0;
  int mark;
  logic exp_err;

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tuser, m_axis_tkeep, busy, err_tlast}, 0);
    check("rst_frame_count", frame_count, 0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // One image, continuous input.
    enable = 1'b1;
    send_beats(14, 100);
    wait_drain("img1_drain");
    check("img1_frames", frame_count, 1);

    // Two back-to-back images must stream out in 28 consecutive cycles.
    mark = pop_cyc_q.size();
    send_beats(28, 100);
    wait_drain("b2b_drain");
    check("b2b_beats", pop_cyc_q.size() - mark, 28);
    if (pop_cyc_q.size() >= mark + 28) check("b2b_span", pop_cyc_q[mark+27] - pop_cyc_q[mark], 27);
    check("b2b_frames", frame_count, 3);

    // Downstream stall of about 20 cycles mid-image.
    fork
      send_beats(14, 200);
      begin
        repeat (4) @(posedge clk); #1;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_s_tready", s_axis_tready, 0);
        repeat (18) @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("stall_drain");
    check("stall_frames", frame_count, 4);

    // Enable dropped once beat 5 is taken: the image still completes, then IDLE.
    cnt0 = in_count;
    fork
      send_beats(14, 100);
      begin
        w = 0;
        while (in_count < cnt0 + 6 && w < 100) begin
          @(posedge clk);
          w++;
        end
        #1 enable = 1'b0;
      end
    join
    wait_drain("drop_drain");
    repeat (2) @(posedge clk); #1;
    check("drop_busy", busy, 0);
    check("drop_s_tready", s_axis_tready, 0);
    check("drop_frames", frame_count, 5);

    // Reset in the middle of an image.
    enable = 1'b1;
    send_beats(7, 100);
    aresetn = 1'b0;
    #1;
    check("midrst_outputs", {m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tuser, m_axis_tkeep, busy, err_tlast}, 0);
    check("midrst_frame_count", frame_count, 0);
    exp_q.delete();
    in_idx = 0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    send_beats(14, 100);
    wait_drain("postrst_drain");
    check("postrst_frames", frame_count, 1);

    // Wrong upstream tlast on beat 4 must not disturb the stream.
    inject_idx = 4;
    send_beats(14, 100);
    inject_idx = -1;
    wait_drain("tlast_drain");
`ifdef CCSDS123_TLAST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("err_tlast_set", err_tlast, exp_err);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("err_tlast_clear", err_tlast, 0);
    check("tlast_frames", frame_count, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
